// File: rtl/cordic_pipeline.sv
// Fully pipelined fixed-point CORDIC: rotation (sin/cos) or vectoring (atan/magnitude),
// one sample per cycle, ITERATION_NUMBER+2 cycle latency.

module cordic_stage #(
  parameter int                  W    = 32,
  parameter int                  IDX  = 0,
  parameter logic signed [W-1:0] ATAN = '0
) (
  input  logic                vec,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] z,
  output logic signed [W-1:0] x_nxt,
  output logic signed [W-1:0] y_nxt,
  output logic signed [W-1:0] z_nxt
);
  logic d_pos;

  // rotation drives z toward 0, vectoring drives y toward 0
  assign d_pos = vec ? y[W-1] : ~z[W-1];

  always_comb begin
    if (d_pos) begin
      x_nxt = x - (y >>> IDX);
      y_nxt = y + (x >>> IDX);
      z_nxt = z - ATAN;
    end else begin
      x_nxt = x + (y >>> IDX);
      y_nxt = y - (x >>> IDX);
      z_nxt = z + ATAN;
    end
  end
endmodule

module cordic_pipeline #(
  parameter int UNSIGNED_INPUT_WIDTH       = 16,
  parameter int UNSIGNED_OUTPUT_WIDTH      = 16,
  parameter int UNSIGNED_INPUT_INT_WIDTH   = 7,
  parameter int UNSIGNED_INPUT_FRAC_WIDTH  = 8,
  parameter int UNSIGNED_OUTPUT_INT_WIDTH  = 7,
  parameter int UNSIGNED_OUTPUT_FRAC_WIDTH = 8,
  parameter int ITERATION_NUMBER           = 6,
  parameter int ITERATION_WORD_WIDTH       = 32,
  parameter int ITERATION_WORD_INT_WIDTH   = 12,
  parameter int ITERATION_WORD_FRAC_WIDTH  = 20,
  parameter int SECTOR_FLAG_WIDTH          = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [UNSIGNED_INPUT_WIDTH-1:0]  degree_in,
  input  logic [UNSIGNED_INPUT_WIDTH-1:0]  x_in,
  input  logic [UNSIGNED_INPUT_WIDTH-1:0]  y_in,
  input  logic [SECTOR_FLAG_WIDTH-1:0]     sector_in,
  input  logic                             arctan_en_in,
  output logic [UNSIGNED_OUTPUT_WIDTH-1:0] degree_out,
  output logic [UNSIGNED_OUTPUT_WIDTH-1:0] x_out,
  output logic [UNSIGNED_OUTPUT_WIDTH-1:0] y_out,
  output logic [SECTOR_FLAG_WIDTH-1:0]     sector_out,
  output logic                             arctan_en_out
);
  localparam int N      = ITERATION_NUMBER;
  localparam int W      = ITERATION_WORD_WIDTH;
  localparam int PW     = 2 * W;
  localparam int FW     = ITERATION_WORD_FRAC_WIDTH;
  localparam int IN_SH  = FW - UNSIGNED_INPUT_FRAC_WIDTH;
  localparam int OUT_SH = FW - UNSIGNED_OUTPUT_FRAC_WIDTH;
  localparam int PAD    = ITERATION_WORD_INT_WIDTH - UNSIGNED_INPUT_INT_WIDTH - 1;

  localparam logic signed [W-1:0] ONE     = W'(1) << FW;
  localparam logic signed [W-1:0] SAT_LIM = W'(1) << (UNSIGNED_OUTPUT_INT_WIDTH + FW);
  localparam logic signed [W-1:0] GAIN_K  = W'($rtoi(0.607253 * (2.0 ** FW) + 0.5));

  function automatic real atan_deg(input int i);
    case (i)
      0:       return 45.0;
      1:       return 26.565051177;
      2:       return 14.036243468;
      3:       return 7.125016349;
      4:       return 3.576334375;
      5:       return 1.789910608;
      default: return 57.295779513 / (2.0 ** i);  // small-angle tail
    endcase
  endfunction

  function automatic logic signed [W-1:0] atan_q(input int i);
    return W'($rtoi(atan_deg(i) * (2.0 ** FW) + 0.5));
  endfunction

  function automatic logic signed [W-1:0] ext(input logic [UNSIGNED_INPUT_WIDTH-1:0] v);
    return {{PAD{1'b0}}, v, {IN_SH{1'b0}}};
  endfunction

  function automatic logic [UNSIGNED_OUTPUT_WIDTH-1:0] to_out(input logic signed [W-1:0] v);
    if (v[W-1])       return '0;
    if (v >= SAT_LIM) return {1'b0, {(UNSIGNED_OUTPUT_WIDTH-1){1'b1}}};
    return v[OUT_SH +: UNSIGNED_OUTPUT_WIDTH];
  endfunction

  logic signed [W-1:0]              x_q   [0:N];
  logic signed [W-1:0]              y_q   [0:N];
  logic signed [W-1:0]              z_q   [0:N];
  logic                             vec_q [0:N];
  logic                             zero_q[0:N];
  logic [SECTOR_FLAG_WIDTH-1:0]     sec_q [0:N];
  logic [UNSIGNED_INPUT_WIDTH-1:0]  ang_q [0:N];
  logic signed [W-1:0]              x_n   [0:N-1];
  logic signed [W-1:0]              y_n   [0:N-1];
  logic signed [W-1:0]              z_n   [0:N-1];

  for (genvar g = 0; g < N; g++) begin : g_stage
    cordic_stage #(.W(W), .IDX(g), .ATAN(atan_q(g))) u_stage (
      .vec(vec_q[g]), .x(x_q[g]), .y(y_q[g]), .z(z_q[g]),
      .x_nxt(x_n[g]), .y_nxt(y_n[g]), .z_nxt(z_n[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= N; i++) begin
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        z_q[i]    <= '0;
        vec_q[i]  <= 1'b0;
        zero_q[i] <= 1'b0;
        sec_q[i]  <= '0;
        ang_q[i]  <= '0;
      end
    end else begin
      x_q[0]    <= arctan_en_in ? ext(x_in) : ONE;
      y_q[0]    <= arctan_en_in ? ext(y_in) : '0;
      z_q[0]    <= arctan_en_in ? '0 : ext(degree_in);
      vec_q[0]  <= arctan_en_in;
      // a zero vector has no angle; remember it so the output can be forced to zero
      zero_q[0] <= arctan_en_in && (x_in == '0) && (y_in == '0);
      sec_q[0]  <= sector_in;
      ang_q[0]  <= degree_in;
      for (int i = 0; i < N; i++) begin
        x_q[i+1]    <= x_n[i];
        y_q[i+1]    <= y_n[i];
        z_q[i+1]    <= z_n[i];
        vec_q[i+1]  <= vec_q[i];
        zero_q[i+1] <= zero_q[i];
        sec_q[i+1]  <= sec_q[i];
        ang_q[i+1]  <= ang_q[i];
      end
    end
  end

  logic signed [PW-1:0] x_prod, y_prod;
  logic signed [W-1:0]  x_cor, y_cor;

  assign x_prod = PW'(x_q[N]) * PW'(GAIN_K);
  assign y_prod = PW'(y_q[N]) * PW'(GAIN_K);
  assign x_cor  = x_prod[FW +: W];
  assign y_cor  = y_prod[FW +: W];

  // gain correction, format conversion and output register share one stage
  always_ff @(posedge clk) begin
    if (reset) begin
      degree_out    <= '0;
      x_out         <= '0;
      y_out         <= '0;
      sector_out    <= '0;
      arctan_en_out <= 1'b0;
    end else begin
      sector_out    <= sec_q[N];
      arctan_en_out <= vec_q[N];
      if (zero_q[N]) begin
        degree_out <= '0;
        x_out      <= '0;
        y_out      <= '0;
      end else if (vec_q[N]) begin
        degree_out <= to_out(z_q[N]);
        x_out      <= to_out(x_cor);
        y_out      <= '0;
      end else begin
        degree_out <= UNSIGNED_OUTPUT_WIDTH'(ang_q[N]);
        x_out      <= to_out(x_cor);
        y_out      <= to_out(y_cor);
      end
    end
  end
endmodule

// File: tb/tb_cordic_pipeline.sv
// Random mixed-mode stream against a real-arithmetic model, with reset flush checks.

module tb_cordic_pipeline;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] degree_in, x_in, y_in;
  logic [1:0]  sector_in;
  logic        arctan_en_in;
  logic [15:0] degree_out, x_out, y_out;
  logic [1:0]  sector_out;
  logic        arctan_en_out;

  cordic_pipeline dut (
    .clk(clk), .reset(reset),
    .degree_in(degree_in), .x_in(x_in), .y_in(y_in),
    .sector_in(sector_in), .arctan_en_in(arctan_en_in),
    .degree_out(degree_out), .x_out(x_out), .y_out(y_out),
    .sector_out(sector_out), .arctan_en_out(arctan_en_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit en;
    int sec, deg, x, y, dtol, xtol, ytol;
  } exp_t;

  exp_t sb [0:1023];
  int   cyc, nchk, nerr;

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    nchk++;
    if (d > tol) begin
      nerr++;
      $display("FAIL %s: got 0x%04h want 0x%04h (+/-%0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int clampq(input real r);
    if (r < 0.0)      return 0;
    if (r >= 32767.0) return 32767;
    return int'($floor(r));
  endfunction

  function automatic exp_t zexp();
    exp_t e;
    e = '{v: 1'b1, en: 1'b0, sec: 0, deg: 0, x: 0, y: 0, dtol: 0, xtol: 0, ytol: 0};
    return e;
  endfunction

  function automatic exp_t model(input bit en, input int deg, input int xv, input int yv, input int sec);
    exp_t e;
    real  pi, a;
    pi = 3.14159265358979;
    e = zexp();
    e.en  = en;
    e.sec = sec;
    if (!en) begin
      a      = (deg / 256.0) * pi / 180.0;
      e.deg  = deg;
      e.x    = clampq($cos(a) * 256.0);
      e.y    = clampq($sin(a) * 256.0);
      e.xtol = 10 + e.x / 100;
      e.ytol = 10 + e.y / 100;
    end else if (xv != 0 || yv != 0) begin
      e.deg  = clampq($atan2(real'(yv), real'(xv)) * 180.0 / pi * 256.0);
      e.dtol = 461;
      e.x    = clampq($sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv)));
      e.xtol = 10 + e.x / 100;
    end
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
    if (sb[cyc].v) begin
      chk($sformatf("deg@%0d", cyc), int'(degree_out), sb[cyc].deg, sb[cyc].dtol);
      chk($sformatf("x@%0d", cyc), int'(x_out), sb[cyc].x, sb[cyc].xtol);
      chk($sformatf("y@%0d", cyc), int'(y_out), sb[cyc].y, sb[cyc].ytol);
      chk($sformatf("sec@%0d", cyc), int'(sector_out), sb[cyc].sec, 0);
      chk($sformatf("en@%0d", cyc), int'(arctan_en_out), int'(sb[cyc].en), 0);
    end
  endtask

  task automatic drive(input bit en, input int deg, input int xv, input int yv, input int sec);
    reset        = 1'b0;
    arctan_en_in = en;
    degree_in    = 16'(deg);
    x_in         = 16'(xv);
    y_in         = 16'(yv);
    sector_in    = 2'(sec);
    sb[cyc+8]    = model(en, deg, xv, yv, sec);
  endtask

  // reset for the coming edge: everything in flight, and the next 8 outputs, are zero
  task automatic rst_cycle();
    reset        = 1'b1;
    arctan_en_in = 1'($urandom);
    degree_in    = 16'($urandom);
    x_in         = 16'($urandom);
    y_in         = 16'($urandom);
    sector_in    = 2'($urandom);
    for (int k = 1; k <= 8; k++) sb[cyc+k] = zexp();
  endtask

  task automatic rnd_item(input int i);
    int sec, xv, yv;
    sec = $urandom_range(0, 3);
    if (i % 2 == 0) begin
      drive(1'b0, $urandom_range(0, 23040), $urandom_range(0, 65535), $urandom_range(0, 65535), sec);
    end else begin
      xv = $urandom_range(0, 32767);
      yv = $urandom_range(0, 32767);
      if ($urandom_range(0, 3) == 0) xv = xv >> 7;
      if ($urandom_range(0, 3) == 0) yv = yv >> 7;
      if (xv == 0 && yv == 0) xv = 1;
      drive(1'b1, $urandom_range(0, 65535), xv, yv, sec);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sb[i].v = 1'b0;
    cyc  = 0;
    nchk = 0;
    nerr = 0;

    rst_cycle();
    repeat (9) begin
      step();
      rst_cycle();
    end
    step();

    drive(1'b0, 16'h0100, 16'h1234, 16'h4321, 0); step();
    drive(1'b0, 16'h1E00, 0, 0, 1);               step();
    drive(1'b1, 16'h7777, 16'h0100, 16'h01BB, 2); step();
    drive(1'b1, 0, 16'h0000, 16'h0100, 3);        step();
    drive(1'b1, 16'h2D00, 16'h0000, 16'h0000, 1); step();
    drive(1'b0, 16'h0000, 0, 0, 2);               step();
    drive(1'b0, 16'h5A00, 0, 0, 3);               step();
    drive(1'b1, 0, 16'h7FFF, 16'h7FFF, 0);        step();

    for (int i = 0; i < 60; i++) begin
      rnd_item(i);
      step();
    end

    rst_cycle();
    step();
    for (int i = 0; i < 60; i++) begin
      rnd_item(i + 1);
      step();
    end

    repeat (9) step();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
